// File: rtl/vscale_pc_gen_if.sv
// Instruction-memory request channel between the PC generator (master) and
// the instruction memory or fetch arbiter (slave).
interface vscale_pc_gen_if #(
   parameter int XLEN = 32
);

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;

   // PC generator side: presents the fetch address, sees the memory's accept.
   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready
   );

   // Memory side: samples the address on valid & ready.
   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready
   );

endinterface : vscale_pc_gen_if

// File: rtl/vscale_pc_gen.sv
// Registered fetch-PC stage for the vscale core.
// Owns PC_IF, selects the next fetch address (PC_PIF, driven on imem_addr),
// and holds any redirect that arrives while fetch cannot advance so that the
// redirect is never dropped.
// Optional feature macro: VSCALE_PC_MISALIGN_CHECK_EN
//   defined   : targets keep bits [1:0]; misaligned_target flags redirects
//               whose target is not word aligned (trap decision is left to
//               the control unit).
//   undefined : target bits [1:0] are forced to zero; misaligned_target = 0.
module vscale_pc_gen #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 'h0000_0200,
   parameter int              SEL_W    = 3
) (
   input  logic             clk,
   input  logic             reset,
   vscale_pc_gen_if.master  imem,
   input  logic [SEL_W-1:0] PC_src_sel,
   input  logic [31:0]      inst_DX,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  PC_DX,
   input  logic [XLEN-1:0]  handler_PC,
   input  logic [XLEN-1:0]  epc,
   input  logic             stall_IF,
   output logic [XLEN-1:0]  PC_IF,
   output logic             redirect_pending,
   output logic             misaligned_target
);

   // ------------------------------------------------------------------
   // Source-select encodings (values 7 and above behave as PLUS_FOUR)
   // ------------------------------------------------------------------
   localparam logic [SEL_W-1:0] SEL_PLUS_FOUR = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_BRANCH    = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_JAL       = SEL_W'(2);
   localparam logic [SEL_W-1:0] SEL_JALR      = SEL_W'(3);
   localparam logic [SEL_W-1:0] SEL_REPLAY    = SEL_W'(4);
   localparam logic [SEL_W-1:0] SEL_HANDLER   = SEL_W'(5);
   localparam logic [SEL_W-1:0] SEL_EPC       = SEL_W'(6);

   // BOOT : first fetch of RESET_PC not yet accepted
   // RUN  : normal fetch, address follows the selected source
   // HOLD : a redirect target is parked until the fetch is accepted
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_if_q, pc_if_d;
   logic [XLEN-1:0] pend_target_q, pend_target_d;

   logic [XLEN-1:0] imm_b, imm_j, imm_i;
   logic [XLEN-1:0] tgt_raw;
   logic [XLEN-1:0] tgt;
   logic            is_redir;
   logic            req_valid;
   logic            advance;
   logic [XLEN-1:0] fetch_addr;
   logic            pending;
   logic            unused_bits;

   // ------------------------------------------------------------------
   // Immediate extraction from the DX instruction
   // ------------------------------------------------------------------
   assign imm_b = {{(XLEN-12){inst_DX[31]}}, inst_DX[7], inst_DX[30:25],
                   inst_DX[11:8], 1'b0};
   assign imm_j = {{(XLEN-20){inst_DX[31]}}, inst_DX[19:12], inst_DX[20],
                   inst_DX[30:21], 1'b0};
   assign imm_i = {{(XLEN-12){inst_DX[31]}}, inst_DX[31:20]};

   // Opcode/register fields are decoded elsewhere; only immediates matter
   // here. Low target bits are dropped when alignment is forced.
   assign unused_bits = ^{inst_DX[6:0], tgt_raw[1:0]};

   // Select the raw next-PC candidate; all sums wrap modulo 2^XLEN.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      tgt_raw  = pc_if_q + XLEN'(4);
      is_redir = 1'b0;
      case (PC_src_sel)
         SEL_BRANCH: begin
            tgt_raw  = PC_DX + imm_b;
            is_redir = 1'b1;
         end
         SEL_JAL: begin
            tgt_raw  = PC_DX + imm_j;
            is_redir = 1'b1;
         end
         SEL_JALR: begin
            tgt_raw  = (rs1_data + imm_i) & ~XLEN'(1);
            is_redir = 1'b1;
         end
         SEL_REPLAY: begin
            tgt_raw  = pc_if_q;
         end
         SEL_HANDLER: begin
            tgt_raw  = handler_PC;
            is_redir = 1'b1;
         end
         SEL_EPC: begin
            tgt_raw  = epc;
            is_redir = 1'b1;
         end
         default: begin
            // SEL_PLUS_FOUR and reserved encodings
            tgt_raw  = pc_if_q + XLEN'(4);
         end
      endcase
   end

`ifdef VSCALE_PC_MISALIGN_CHECK_EN
   // Targets pass through unchanged so the control unit can see the
   // misalignment and decide whether to trap.
   assign tgt = tgt_raw;
`else
   // Without the checker every fetch address is forced word aligned.
   assign tgt = {tgt_raw[XLEN-1:2], 2'b00};
`endif

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   assign req_valid = ~reset;
   assign advance   = req_valid & imem.imem_req_ready & ~stall_IF;

   // Next-state, fetch address and held-target update for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      pc_if_d       = pc_if_q;
      pend_target_d = pend_target_q;
      fetch_addr    = tgt;
      pending       = 1'b0;
      case (state_q)
         ST_BOOT: begin
            fetch_addr = RESET_PC;
            if (advance) begin
               pc_if_d = RESET_PC;
            end
            // The boot fetch occupies the address port, so any redirect
            // seen here must be parked regardless of acceptance.
            if (is_redir) begin
               pend_target_d = tgt;
               state_d       = ST_HOLD;
            end else if (advance) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            fetch_addr = tgt;
            if (advance) begin
               // Zero-cycle redirect: an accepted target is taken directly.
               pc_if_d = tgt;
            end else if (is_redir) begin
               pend_target_d = tgt;
               state_d       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            pending = 1'b1;
            // Youngest redirect wins; sequential sources are ignored.
            if (is_redir) begin
               fetch_addr    = tgt;
               pend_target_d = tgt;
            end else begin
               fetch_addr = pend_target_q;
            end
            if (advance) begin
               pc_if_d = fetch_addr;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State, PC_IF and held-target registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         pc_if_q       <= RESET_PC;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_if_q       <= pc_if_d;
         pend_target_q <= pend_target_d;
      end
   end

   // ------------------------------------------------------------------
   // Misaligned-target flag
   // ------------------------------------------------------------------
`ifdef VSCALE_PC_MISALIGN_CHECK_EN
   logic tgt_misaligned;
   logic pend_misaligned;

   assign tgt_misaligned  = is_redir & (tgt[1:0] != 2'b00);
   assign pend_misaligned = (state_q == ST_HOLD) & ~is_redir &
                            (pend_target_q[1:0] != 2'b00);

   // Flag a live misaligned redirect, or a misaligned target still held.
   always_comb begin
      misaligned_target = 1'b0;
      if (!reset) begin
         misaligned_target = tgt_misaligned | pend_misaligned;
      end
   end
`else
   assign misaligned_target = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign imem.imem_req_valid = req_valid;
   assign imem.imem_addr      = fetch_addr;
   assign PC_IF               = pc_if_q;
   assign redirect_pending    = pending & ~reset;

endmodule : vscale_pc_gen

// File: tb/tb_vscale_pc_gen.sv
// Directed self-checking bench for vscale_pc_gen. Expected values are
// hand-computed from the RISC-V immediate encodings used in each step.
// Honors VSCALE_PC_MISALIGN_CHECK_EN for the alignment-dependent steps.
module tb_vscale_pc_gen;

   localparam int XLEN = 32;

   localparam logic [2:0] S_PLUS4   = 3'd0;
   localparam logic [2:0] S_BRANCH  = 3'd1;
   localparam logic [2:0] S_JAL     = 3'd2;
   localparam logic [2:0] S_JALR    = 3'd3;
   localparam logic [2:0] S_HANDLER = 3'd5;
   localparam logic [2:0] S_EPC     = 3'd6;
   localparam logic [2:0] S_RSVD    = 3'd7;

   logic            clk = 1'b0;
   logic            reset;
   logic [2:0]      PC_src_sel;
   logic [31:0]     inst_DX;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] PC_DX;
   logic [XLEN-1:0] handler_PC;
   logic [XLEN-1:0] epc;
   logic            stall_IF;
   logic [XLEN-1:0] PC_IF;
   logic            redirect_pending;
   logic            misaligned_target;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] acc_addr = '0;
   logic            seen_500 = 1'b0;

   vscale_pc_gen_if #(.XLEN(XLEN)) imem_if ();

   vscale_pc_gen #(
      .XLEN     (XLEN),
      .RESET_PC (32'h0000_0200),
      .SEL_W    (3)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .imem              (imem_if.master),
      .PC_src_sel        (PC_src_sel),
      .inst_DX           (inst_DX),
      .rs1_data          (rs1_data),
      .PC_DX             (PC_DX),
      .handler_PC        (handler_PC),
      .epc               (epc),
      .stall_IF          (stall_IF),
      .PC_IF             (PC_IF),
      .redirect_pending  (redirect_pending),
      .misaligned_target (misaligned_target)
   );

   always #5 clk = ~clk;

   // Record every address the memory actually accepts.
   always @(posedge clk) begin
      if (imem_if.imem_req_valid && imem_if.imem_req_ready && !stall_IF) begin
         acc_addr <= imem_if.imem_addr;
         if (imem_if.imem_addr == 32'h0000_0500) seen_500 <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

`ifdef VSCALE_PC_MISALIGN_CHECK_EN
   localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_0602;
   localparam logic [31:0] EXP_MIS_FLAG = 32'd1;
`else
   localparam logic [31:0] EXP_MIS_ADDR = 32'h0000_0600;
   localparam logic [31:0] EXP_MIS_FLAG = 32'd0;
`endif

   initial begin
      reset                  = 1'b1;
      PC_src_sel             = S_PLUS4;
      inst_DX                = 32'h0000_0013;
      rs1_data               = '0;
      PC_DX                  = '0;
      handler_PC             = '0;
      epc                    = '0;
      stall_IF               = 1'b0;
      imem_if.imem_req_ready = 1'b0;

      // Reset state
      step();
      step();
      check("rst_valid",   imem_if.imem_req_valid, 0);
      check("rst_pending", redirect_pending, 0);
      check("rst_misal",   misaligned_target, 0);
      check("rst_pc_if",   PC_IF, 32'h200);

      // Sequential fetch from RESET_PC
      reset = 1'b0;
      imem_if.imem_req_ready = 1'b1;
      #1;
      check("boot_valid", imem_if.imem_req_valid, 1);
      check("boot_addr",  imem_if.imem_addr, 32'h200);
      step();
      check("seq_pc0",   PC_IF, 32'h200);
      check("seq_addr1", imem_if.imem_addr, 32'h204);
      step();
      check("seq_pc1",   PC_IF, 32'h204);
      check("seq_addr2", imem_if.imem_addr, 32'h208);
      step();
      check("seq_pc2",   PC_IF, 32'h208);

      // JAL +0x40 from 0x300, accepted same cycle
      PC_DX      = 32'h300;
      inst_DX    = 32'h0400_006F;
      PC_src_sel = S_JAL;
      #1;
      check("jal_addr",    imem_if.imem_addr, 32'h340);
      check("jal_pending", redirect_pending, 0);
      step();
      check("jal_pc_if",   PC_IF, 32'h340);
      check("jal_pend_nx", redirect_pending, 0);
      PC_src_sel = S_PLUS4;
      #1;
      check("jal_next_addr", imem_if.imem_addr, 32'h344);

      // stall_IF blocks acceptance even with ready high
      stall_IF = 1'b1;
      step();
      check("stall_pc_if", PC_IF, 32'h340);
      stall_IF = 1'b0;

      // BRANCH -8 from 0x400 while memory not ready for 3 cycles
      PC_DX      = 32'h400;
      inst_DX    = 32'hFE00_0CE3;
      PC_src_sel = S_BRANCH;
      imem_if.imem_req_ready = 1'b0;
      #1;
      check("br_addr0", imem_if.imem_addr, 32'h3F8);
      check("br_pend0", redirect_pending, 0);
      step();
      check("br_addr1", imem_if.imem_addr, 32'h3F8);
      check("br_pend1", redirect_pending, 1);
      step();
      check("br_addr2", imem_if.imem_addr, 32'h3F8);
      check("br_pend2", redirect_pending, 1);
      step();
      PC_src_sel = S_PLUS4;
      imem_if.imem_req_ready = 1'b1;
      #1;
      check("br_addr3", imem_if.imem_addr, 32'h3F8);
      check("br_pend3", redirect_pending, 1);
      step();
      check("br_pc_if",   PC_IF, 32'h3F8);
      check("br_acc",     acc_addr, 32'h3F8);
      check("br_pend_nx", redirect_pending, 0);

      // Held EPC 0x500 replaced by HANDLER 0x100 before acceptance
      epc        = 32'h500;
      PC_src_sel = S_EPC;
      imem_if.imem_req_ready = 1'b0;
      #1;
      check("epc_addr", imem_if.imem_addr, 32'h500);
      step();
      PC_src_sel = S_PLUS4;
      #1;
      check("hold_ign_addr", imem_if.imem_addr, 32'h500);
      check("hold_ign_pend", redirect_pending, 1);
      step();
      handler_PC = 32'h100;
      PC_src_sel = S_HANDLER;
      #1;
      check("hnd_addr", imem_if.imem_addr, 32'h100);
      step();
      PC_src_sel = S_PLUS4;
      imem_if.imem_req_ready = 1'b1;
      #1;
      check("hnd_addr_held", imem_if.imem_addr, 32'h100);
      step();
      check("hnd_pc_if", PC_IF, 32'h100);
      check("hnd_acc",   acc_addr, 32'h100);
      check("no_500",    seen_500, 0);

      // JALR wrap-around: 0xFFFF_FFFF + 2 = 1, bit0 cleared -> 0
      rs1_data   = 32'hFFFF_FFFF;
      inst_DX    = 32'h0020_0067;
      PC_src_sel = S_JALR;
      #1;
      check("jalr_addr",  imem_if.imem_addr, 32'h0);
      check("jalr_misal", misaligned_target, 0);
      step();
      check("jalr_pc_if", PC_IF, 32'h0);

      // JAL to PC_DX+2: misaligned target
      PC_DX      = 32'h600;
      inst_DX    = 32'h0020_006F;
      PC_src_sel = S_JAL;
      #1;
      check("mis_addr", imem_if.imem_addr, EXP_MIS_ADDR);
      check("mis_flag", misaligned_target, EXP_MIS_FLAG);
      step();
      check("mis_pc_if", PC_IF, EXP_MIS_ADDR);

      // Park the misaligned target in HOLD, then reset mid-HOLD
      imem_if.imem_req_ready = 1'b0;
      step();
      PC_src_sel = S_PLUS4;
      #1;
      check("mis_hold_pend", redirect_pending, 1);
      check("mis_hold_flag", misaligned_target, EXP_MIS_FLAG);
      check("mis_hold_addr", imem_if.imem_addr, EXP_MIS_ADDR);
      reset = 1'b1;
      #1;
      check("rst_hold_valid", imem_if.imem_req_valid, 0);
      check("rst_hold_pend",  redirect_pending, 0);
      check("rst_hold_misal", misaligned_target, 0);
      step();
      reset = 1'b0;
      imem_if.imem_req_ready = 1'b1;
      #1;
      check("post_rst_pc_if", PC_IF, 32'h200);
      check("post_rst_pend",  redirect_pending, 0);
      check("post_rst_addr",  imem_if.imem_addr, 32'h200);
      step();
      check("post_rst_acc",   acc_addr, 32'h200);
      check("post_rst_pc_nx", PC_IF, 32'h200);

      // Redirect arriving in BOOT is parked, then taken
      reset = 1'b1;
      step();
      reset      = 1'b0;
      PC_DX      = 32'h700;
      inst_DX    = 32'h0400_006F;
      PC_src_sel = S_JAL;
      imem_if.imem_req_ready = 1'b0;
      #1;
      check("boot_redir_addr", imem_if.imem_addr, 32'h200);
      step();
      check("boot_redir_pend", redirect_pending, 1);
      check("boot_redir_tgt",  imem_if.imem_addr, 32'h740);
      PC_src_sel = S_RSVD;
      imem_if.imem_req_ready = 1'b1;
      #1;
      check("rsvd_hold_addr", imem_if.imem_addr, 32'h740);
      step();
      check("boot_redir_pc", PC_IF, 32'h740);
      check("rsvd_run_addr", imem_if.imem_addr, 32'h744);
      step();
      check("rsvd_run_pc",   PC_IF, 32'h744);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_vscale_pc_gen

// File: doc/vscale_pc_gen.md
Name: vscale_pc_gen

Overview:
- Next-generation PC generation unit. Replaces the purely combinational next-PC mux with a parametrised, registered fetch-PC stage.
- Owns PC_IF, computes the next fetch address (PC_PIF), and drives the instruction-memory request handshake.
- Holds a redirect (branch/jump/trap/eret) that arrives while fetch is stalled, so the redirect is never lost.
- Optionally checks target alignment and reports misaligned targets.

Parameters:
- XLEN, 32, datapath and PC width; min 32.
- RESET_PC, 32'h0000_0200, first fetch address after reset.
- SEL_W, 3, width of PC_src_sel.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- PC_src_sel  in  SEL_W  next-PC source: 0 PLUS_FOUR, 1 BRANCH, 2 JAL, 3 JALR, 4 REPLAY, 5 HANDLER, 6 EPC, 7 reserved (treated as PLUS_FOUR)
- inst_DX  in  32  instruction in DX, used for immediates
- rs1_data  in  XLEN  JALR base
- PC_DX  in  XLEN  PC of the DX instruction
- handler_PC  in  XLEN  trap vector
- epc  in  XLEN  exception return PC
- stall_IF  in  1  pipeline cannot accept a new fetch
- imem_req_ready  in  1  memory accepts the address this cycle
- imem_req_valid  out  1  fetch request valid
- imem_addr  out  XLEN  = PC_PIF, the fetch address presented
- PC_IF  out  XLEN  registered PC of the instruction in IF
- redirect_pending  out  1  a held redirect target is outstanding
- misaligned_target  out  1  redirect target has [1:0]!=0 (feature only)

Behaviour:
- Clocking/reset: single clock `clk`. `reset` is synchronous and active-high. On reset:
  - PC_IF<=RESET_PC, state<=BOOT, pend_target<=0;
  - imem_req_valid=0 during the reset cycle; redirect_pending=0; misaligned_target=0.
- advance = imem_req_valid & imem_req_ready & !stall_IF.
- Target arithmetic: all sums are XLEN-bit modulo 2^XLEN, with wrap-around permitted and no flag.
  - imm_b = sext{inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - jal = sext{inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - jalr = sext(inst[31:20]) added to rs1_data, then bit0 cleared per ISA.
- Source decode, giving tgt:
  - BRANCH: PC_DX+imm_b.
  - JAL: PC_DX+jal.
  - JALR: (rs1_data+imm_i)&~1.
  - HANDLER: handler_PC.
  - EPC: epc.
  - REPLAY: PC_IF.
  - PLUS_FOUR: PC_IF+4.
  - is_redir = sel in {1,2,3,5,6}.
- States:
  - BOOT: imem_addr=RESET_PC.
    - On advance: PC_IF<=RESET_PC, go RUN.
    - A redirect in BOOT is latched as in RUN, and the state goes HOLD.
  - RUN: imem_addr=tgt.
    - On advance: PC_IF<=tgt.
    - If is_redir & !advance: pend_target<=tgt, go HOLD.
  - HOLD: imem_addr=pend_target, redirect_pending=1.
    - A new is_redir replaces the held target: pend_target<=tgt, and imem_addr=tgt that same cycle (youngest redirect wins).
    - PLUS_FOUR/REPLAY are ignored in HOLD.
    - On advance: PC_IF<=imem_addr, go RUN.
- imem_req_valid=1 in every state when not in reset.
- imem_addr may change while imem_req_ready=0; the handshake is address-sampled only on advance.
- Simultaneous redirect+advance in RUN: the target is taken directly and the state stays RUN (zero-cycle redirect latency; next cycle PC_IF=tgt).
- Reset mid-HOLD: the held target is discarded and the unit returns to BOOT.

Optional Feature:
- Macro: VSCALE_PC_MISALIGN_CHECK_EN.
- Defined:
  - misaligned_target=1 combinationally when is_redir and tgt[1:0]!=0.
  - The redirect is still followed, with the address unchanged; the trap decision belongs to the control unit.
  - A held pend_target also re-asserts the flag while in HOLD.
- Undefined:
  - tgt[1:0] is forced to 2'b00 for all sources.
  - misaligned_target is tied to 0.

Test Plan:
- Reset then ready=1, no stall, sel=PLUS_FOUR for 3 cycles -> imem_addr 0x200,0x204,0x208; PC_IF 0x200,0x204,0x208.
- RUN, PC_DX=0x300, JAL inst with offset +0x40, ready=1 -> same-cycle imem_addr=0x340; next cycle PC_IF=0x340, redirect_pending=0.
- BRANCH offset -8 from PC_DX=0x400 while imem_req_ready=0 for 3 cycles, then sel=PLUS_FOUR, ready=1 -> redirect_pending=1 for 3 cycles, imem_addr=0x3F8 throughout; PC_IF=0x3F8 after acceptance.
- HOLD with pend=0x500, then HANDLER (handler_PC=0x100) while still stalled -> imem_addr switches to 0x100; after advance PC_IF=0x100; 0x500 never fetched.
- JALR rs1=0xFFFF_FFFF, imm=+2 -> target 0x0000_0000 (wrap, bit0 cleared); with the macro defined, JAL to PC_DX+2 -> misaligned_target=1 and imem_addr ends in 2'b10; with the macro undefined, imem_addr ends in 2'b00 and flag=0.
- Assert reset during HOLD -> next cycle PC_IF=0x200, state BOOT, redirect_pending=0; first accepted fetch=0x200.
